// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder slice plus a carry flop, LSB first, W+1 cycle latency.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and a forced carry-in of 1).
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    ra_q, ra_d;
  logic [W-1:0]    rb_q, rb_d;
  logic [W-1:0]    ps_q, ps_d;
  logic [W-1:0]    s_q, s_d;
  logic            c_q, c_d;
  logic            co_q, co_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    b_load;
  logic            c_load;
  logic            fa_sum;
  logic            fa_carry;
  logic [W-1:0]    ps_next;

  // Operand conditioning at capture time; subtraction is a + ~b + 1.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : ci;
`else
    b_load = b;
    c_load = ci;
`endif
  end

  always_comb begin
    fa_sum   = ra_q[0] ^ rb_q[0] ^ c_q;
    fa_carry = (ra_q[0] & rb_q[0]) | (c_q & (ra_q[0] ^ rb_q[0]));
    ps_next  = (ps_q >> 1) | (W'(fa_sum) << (W - 1));
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    ps_d    = ps_q;
    s_d     = s_q;
    c_d     = c_q;
    co_d    = co_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b_load;
          c_d     = c_load;
          ps_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        c_d   = fa_carry;
        ps_d  = ps_next;
        cnt_d = cnt_q + CW'(1);
        // Last bit: publish the sum including this cycle's bit.
        if (cnt_q == CW'(W - 1)) begin
          s_d     = ps_next;
          co_d    = fa_carry;
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      ps_q    <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ps_q    <= ps_d;
      s_q     <= s_d;
      c_q     <= c_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: W=8 and W=1 instances against a behavioural model,
// plus directed vectors with hand-computed results.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       ci8 = 1'b0;
   logic       sub8 = 1'b0;
   logic       busy8, done8, co8;
   logic [7:0] s8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       ci1 = 1'b0;
   logic       sub1 = 1'b0;
   logic       busy1, done1, co1;
   logic [0:0] s1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_adder #(.W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub8),
`endif
      .busy(busy8), .done(done8), .s(s8), .co(co8)
   );

   serial_adder #(.W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub1),
`endif
      .busy(busy1), .done(done1), .s(s1), .co(co1)
   );

   // Reference arithmetic: plain (W+1)-bit sums, subtraction as a + ~b + 1.
   function automatic logic [8:0] sumModel8(logic [7:0] a, logic [7:0] b, logic ci, logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + 9'd1;
      return {1'b0, a} + {1'b0, b} + {8'd0, ci};
   endfunction

   function automatic logic [1:0] sumModel1(logic a, logic b, logic ci, logic sub);
      if (sub) return {1'b0, a} + {1'b0, ~b} + 2'd1;
      return {1'b0, a} + {1'b0, b} + {1'b0, ci};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: an accepted op occupies W cycles, then shows its result with done for one cycle.
   logic       mBusy8 = 0, mDone8 = 0, mCo8 = 0;
   logic [7:0] mS8 = '0;
   logic [8:0] pend8 = '0;
   int         mLeft8 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy8 <= 0; mDone8 <= 0; mS8 <= '0; mCo8 <= 0; mLeft8 <= 0;
      end else if (mBusy8) begin
         if (mLeft8 == 1) begin
            mBusy8 <= 0; mDone8 <= 1; mS8 <= pend8[7:0]; mCo8 <= pend8[8];
         end
         mLeft8 <= mLeft8 - 1;
      end else begin
         mDone8 <= 0;
         if (start8) begin
            pend8 <= sumModel8(a8, b8, ci8, sub8);
            mBusy8 <= 1;
            mLeft8 <= 8;
         end
      end
   end

   logic       mBusy1 = 0, mDone1 = 0, mCo1 = 0;
   logic [0:0] mS1 = '0;
   logic [1:0] pend1 = '0;
   int         mLeft1 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy1 <= 0; mDone1 <= 0; mS1 <= '0; mCo1 <= 0; mLeft1 <= 0;
      end else if (mBusy1) begin
         if (mLeft1 == 1) begin
            mBusy1 <= 0; mDone1 <= 1; mS1 <= pend1[0]; mCo1 <= pend1[1];
         end
         mLeft1 <= mLeft1 - 1;
      end else begin
         mDone1 <= 0;
         if (start1) begin
            pend1 <= sumModel1(a1[0], b1[0], ci1, sub1);
            mBusy1 <= 1;
            mLeft1 <= 1;
         end
      end
   end

   // Every falling edge, both instances must agree with the model.
   always @(negedge clk) begin
      checkOutput("busy8", {31'd0, busy8}, {31'd0, mBusy8});
      checkOutput("done8", {31'd0, done8}, {31'd0, mDone8});
      checkOutput("s8", {24'd0, s8}, {24'd0, mS8});
      checkOutput("co8", {31'd0, co8}, {31'd0, mCo8});
      checkOutput("busy1", {31'd0, busy1}, {31'd0, mBusy1});
      checkOutput("done1", {31'd0, done1}, {31'd0, mDone1});
      checkOutput("s1", {31'd0, s1}, {31'd0, mS1});
      checkOutput("co1", {31'd0, co1}, {31'd0, mCo1});
   end

   // Drives one request on dut8; returns at the first falling edge after the accepting edge.
   task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
      a8 = a; b8 = b; ci8 = ci; sub8 = sub; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Counts falling edges since the accepting edge until done8, bounded.
   task automatic waitDone8(input int startCount, input int expCount, input string tag);
      int n = startCount;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_latency"}, n, expCount);
      checkOutput({tag, "_done"}, {31'd0, done8}, 32'd1);
      checkOutput({tag, "_busyLow"}, {31'd0, busy8}, 32'd0);
   endtask

   logic [7:0] fullAddSum = 8'b1001_0110;
   logic [7:0] fullAddCarry = 8'b1110_1000;

   initial begin
      #3;
      checkOutput("rst_busy8", {31'd0, busy8}, 32'd0);
      checkOutput("rst_done8", {31'd0, done8}, 32'd0);
      checkOutput("rst_s8", {24'd0, s8}, 32'd0);
      checkOutput("rst_co8", {31'd0, co8}, 32'd0);
      checkOutput("rst_s1", {31'd0, s1}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // W=1 full-adder truth table, index = {a,b,ci}.
      for (int i = 0; i < 8; i++) begin
         a1 = i[2]; b1 = i[1]; ci1 = i[0]; start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         checkOutput("w1_busy", {31'd0, busy1}, 32'd1);
         @(negedge clk);
         checkOutput("w1_done", {31'd0, done1}, 32'd1);
         checkOutput("w1_s", {31'd0, s1}, {31'd0, fullAddSum[i]});
         checkOutput("w1_co", {31'd0, co1}, {31'd0, fullAddCarry[i]});
         @(negedge clk);
      end

      applyStimulus8(8'hFF, 8'h01, 1'b0, 1'b0);
      checkOutput("ff01_busy", {31'd0, busy8}, 32'd1);
      waitDone8(1, 9, "ff01");
      checkOutput("ff01_s", {24'd0, s8}, 32'h00);
      checkOutput("ff01_co", {31'd0, co8}, 32'd1);
      @(negedge clk);

      // Start pulse mid-operation must be ignored.
      applyStimulus8(8'h5A, 8'h33, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      a8 = 8'h00; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      waitDone8(4, 9, "5a33");
      checkOutput("5a33_s", {24'd0, s8}, 32'h8E);
      checkOutput("5a33_co", {31'd0, co8}, 32'd0);
      @(negedge clk);
      checkOutput("5a33_hold_done", {31'd0, done8}, 32'd0);
      checkOutput("5a33_hold_s", {24'd0, s8}, 32'h8E);

      // Back-to-back with start held high; second op accepted in the DONE cycle.
      a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      waitDone8(1, 9, "b2b1");
      checkOutput("b2b1_s", {24'd0, s8}, 32'h10);
      checkOutput("b2b1_co", {31'd0, co8}, 32'd0);
      a8 = 8'h80; b8 = 8'h80;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("b2b2_s_held", {24'd0, s8}, 32'h10);
      waitDone8(1, 9, "b2b2");
      checkOutput("b2b2_s", {24'd0, s8}, 32'h00);
      checkOutput("b2b2_co", {31'd0, co8}, 32'd1);
      @(negedge clk);

      // Reset after four bits of AA+55.
      applyStimulus8(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {31'd0, busy8}, 32'd0);
      checkOutput("midrst_done", {31'd0, done8}, 32'd0);
      checkOutput("midrst_s", {24'd0, s8}, 32'd0);
      checkOutput("midrst_co", {31'd0, co8}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      applyStimulus8(8'hAA, 8'h55, 1'b0, 1'b0);
      waitDone8(1, 9, "aa55");
      checkOutput("aa55_s", {24'd0, s8}, 32'hFF);
      checkOutput("aa55_co", {31'd0, co8}, 32'd0);
      @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
      applyStimulus8(8'h10, 8'h01, 1'b1, 1'b1);
      waitDone8(1, 9, "sub1001");
      checkOutput("sub1001_s", {24'd0, s8}, 32'h0F);
      checkOutput("sub1001_co", {31'd0, co8}, 32'd1);
      @(negedge clk);
      applyStimulus8(8'h01, 8'h02, 1'b1, 1'b1);
      waitDone8(1, 9, "sub0102");
      checkOutput("sub0102_s", {24'd0, s8}, 32'hFF);
      checkOutput("sub0102_co", {31'd0, co8}, 32'd0);
      sub8 = 1'b0;
      @(negedge clk);
`endif

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial W-bit adder built around a single full-adder cell and a carry flip-flop. It accepts two W-bit operands and a carry-in on a start handshake and processes one bit per clock, LSB first. It returns a registered W-bit sum and carry-out with a one-cycle done pulse. It sits directly downstream of the full adder cell and turns that combinational slice into a multi-bit, area-minimal arithmetic stage for the datapath.

## Interface
- W, default 8: operand/sum width; legal range 1..32.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only while busy=0.
- a  in  W  operand A, captured on an accepted start.
- b  in  W  operand B, captured on an accepted start.
- ci  in  1  carry-in, captured on an accepted start.
- sub  in  1  subtract select, captured on an accepted start; present only when SERIAL_ADDER_SUB_EN is defined.
- busy  out  1  high while the operation is in progress.
- done  out  1  one-cycle pulse when s/co hold a new result.
- s  out  W  registered sum.
- co  out  1  registered carry-out.

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: W cycles of bit processing.
  - DONE: one cycle.
- IDLE/DONE with start=1: capture a into shift register ra, b into rb, ci into carry register c. Clear bit counter cnt to 0. Go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle:
  - bit = ra[0]^rb[0]^c
  - c <= (ra[0]&rb[0]) | (c&(ra[0]^rb[0]))
  - ra and rb shift right one place.
  - bit shifts into the MSB of the partial-sum register ps.
  - cnt increments.
- RUN exit: on the cycle where cnt==W-1, load s <= final ps (including this bit), load co <= the new carry, and go to DONE.
- s and co change only at the RUN→DONE transition. They hold the last result through IDLE and through the following RUN.
- start while busy=1 is ignored; it is neither queued nor does it disturb the operation in flight.
- Arithmetic is modulo 2^W. co is the true carry out of bit W-1. No overflow flag.
- cnt width is clog2(W) and at least 1 bit. For W=1, RUN lasts exactly one cycle.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE
  - busy=0, done=0
  - s=0, co=0
  - ra, rb, ps, c and cnt all 0.
- Start accepted at edge k:
  - busy=1 after edge k.
  - Bits processed at edges k+1 .. k+W.
  - After edge k+W: busy=0, done=1, s/co valid.
  - After edge k+W+1: done=0.
- Latency from the accepting edge to done: W+1 edges.
- Throughput: one operation per W+1 cycles. Back-to-back is supported because start is accepted in the DONE cycle.
- busy and done are never high simultaneously.
- Reset asserted mid-RUN aborts immediately. All outputs return to reset values and the partial result is discarded.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub port exists.
  - Accepted start with sub=1 captures ~b into rb and forces c=1; ci is ignored.
  - The result is a-b mod 2^W, with co=1 meaning no borrow.
  - sub=0 behaves as plain add.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port and no inversion logic; add only.
  - Timing is identical in both builds.

## Test plan
- W=1, all 8 (a,b,ci) combinations, each -> s,co match the full adder truth table (e.g. 1,1,1 -> s=1, co=1). done arrives 2 edges after start.
- W=8, a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1. done high exactly 9 edges after the accepting edge. busy high for the 8 cycles before it.
- W=8, a=8'h5A, b=8'h33, ci=1 -> s=8'h8E, co=0. Then start pulsed again during busy with a=8'h00 -> ignored; result stays 8'h8E.
- Back-to-back: start held high. First op 8'h0F+8'h01 -> 8'h10, co=0. Second op accepted in the DONE cycle, 8'h80+8'h80 -> 8'h00, co=1. done pulses are separated by 9 cycles.
- Reset mid-RUN (rst_n low at bit 4 of 8'hAA+8'h55):
  - Required: busy=0, done=0, s=0, co=0 immediately.
  - A new start after release gives a clean 8'hFF, co=0.
- With SERIAL_ADDER_SUB_EN:
  - 8'h10-8'h01 -> s=8'h0F, co=1.
  - 8'h01-8'h02 -> s=8'hFF, co=0.
  - ci=1 is ignored in both cases.
